systolic_output_drain: RTL and testbench
========================================

Name: systolic_output_drain

Overview:
Downstream collector for the tiled systolic MAC array.
- Waits for the array's compute_done, then snapshots every PE partial sum into an internal accumulator bank.
- Pulses the array's clear, and repeats this over num_k_tiles input tiles so that K-dimension partial sums are summed.
- After the last tile, streams the accumulated result out one row per beat over a valid/ready interface.

Parameters:
num_row, 3, array rows (output rows per result tile)
num_col, 3, array columns (words per output beat)
out_word_size, 16, width of one PE register value from the array
acc_word_size, 24, accumulator and output word width (must be >= out_word_size)
num_k_tiles, 2, input tiles summed per result tile (>= 1)

Ports:
clk  input  1  clock
reset  input  1  synchronous, active-high reset
compute_done  input  1  level from array; high once current tile is computed, low after array is cleared
pe_register_vals  input  out_word_size*num_row*num_col  flat, ascending range [0:N-1]; PE (r,c) occupies word index r*num_col+c, bits [out_word_size*idx : out_word_size*(idx+1)-1]
array_reset  output  1  registered clear to array (drives its reset)
out_valid  output  1  output row valid
out_ready  input  1  downstream accepts row
out_data  output  acc_word_size*num_col  ascending range; column c at [acc_word_size*c : acc_word_size*(c+1)-1]
out_row  output  clog2(num_row) (min 1)  row index of current beat
out_last  output  1  high with row num_row-1
tile_done  output  1  one-cycle pulse after last row accepted
busy  output  1  high in any state other than WAIT

Behaviour:
- Reset: reset, synchronous, active-high; clock clk. On reset: state=WAIT, k_idx=0, row_idx=0, accumulators=0, array_reset=1, out_valid=0, out_last=0, tile_done=0, busy=0, out_row=0. array_reset drops to 0 in the first cycle after reset deasserts.
- Reset mid-operation (any state) aborts everything: partial accumulations are discarded and no tile_done is produced.
- Accumulator bank: num_row*num_col words of acc_word_size. PE values are zero-extended. Sums wrap modulo 2^acc_word_size.
- WAIT: at the edge where compute_done=1:
  - if k_idx==0, acc[i] <= pe[i]; otherwise acc[i] <= acc[i]+pe[i];
  - array_reset <= 1; go to CLEAR.
- CLEAR: array_reset is high for exactly this one cycle; at the next edge array_reset <= 0.
  - If k_idx==num_k_tiles-1: k_idx <= 0, row_idx <= 0, out_valid <= 1; go to DRAIN.
  - Otherwise: k_idx <= k_idx+1; go to SETTLE.
- SETTLE: wait until compute_done==0, then go to WAIT. This prevents double capture of one tile. Minimum dwell is 1 cycle.
- DRAIN:
  - out_data = acc row row_idx; out_row = row_idx; out_last = (row_idx==num_row-1).
  - out_valid stays high and out_data/out_row/out_last stay stable until out_ready=1 at a clock edge.
  - On accept with not last: row_idx++, and valid stays high, giving back-to-back beats.
  - On accept with last: out_valid <= 0, tile_done <= 1 for one cycle; go to WAIT.
  - out_ready is ignored outside DRAIN.
  - compute_done is ignored in DRAIN. The array has already been cleared and may recompute; its next done is captured on return to WAIT.
- Latency: compute_done seen at edge t gives array_reset high during t..t+1. On the final tile, out_valid is high from t+1. With out_ready held at 1, tile_done is high during cycle t+1+num_row.
- num_k_tiles=1: CLEAR goes straight to DRAIN, with no SETTLE visit.

Decomposition:
- Shared package: state encoding (WAIT, CLEAR, SETTLE, DRAIN), the clog2 helper function, and index macros for flat word slicing (shared with systolic_array and the input feeder).
- One sub-module, acc_bank: the num_row*num_col accumulator registers with load/add/clear controls and a row-select read port.
- FSM, counters and handshake remain in the top module.

Test Plan:
- Reset: hold reset 3 cycles -> array_reset=1, out_valid=0, busy=0, tile_done=0; the cycle after release array_reset=0.
- Basic K=2 (3x3, acc 24):
  - tile1 pe(r,c)=3r+c+1, tile2 pe=10*(3r+c+1), out_ready=1;
  - expected rows {11,22,33}, {44,55,66}, {77,88,99};
  - out_row 0,1,2 back-to-back; out_last on row 2; tile_done 1 cycle later; exactly 2 array_reset pulses, 1 cycle each.
- Backpressure: out_ready low 4 cycles on row 1 -> out_valid held, row 1 data unchanged, no row skipped, tile_done delayed by 4 cycles.
- Wrap: acc_word_size=16 override, both tiles pe=0xFFFF -> every output word 0xFFFE.
- No double capture: compute_done held high 5 extra cycles after array_reset pulse -> only one accumulation, and the SETTLE dwell is observed.
- Reset mid-drain: assert reset after row 0 is accepted -> out_valid=0 next cycle, no tile_done; next full run produces correct fresh sums with no stale accumulation.

Source files
------------

// File: rtl/systolic_output_drain_pkg.sv
// Shared state encoding, index-width helpers and flat-bus word slicing for the
// systolic array, its input feeder and the output drain.
`ifndef SYSTOLIC_OUTPUT_DRAIN_PKG_SV
`define SYSTOLIC_OUTPUT_DRAIN_PKG_SV

// Word idx of an ascending flat bus [0:N-1] made of w-bit words.
`define SOD_WORD_LO(w, idx) ((w) * (idx))
`define SOD_WORD(vec, w, idx) vec[`SOD_WORD_LO(w, idx) +: (w)]

package systolic_output_drain_pkg;

  typedef enum logic [1:0] {
    WAIT   = 2'd0,
    CLEAR  = 2'd1,
    SETTLE = 2'd2,
    DRAIN  = 2'd3
  } drain_state_t;

  function automatic int unsigned clog2(input int unsigned value);
    int unsigned width;
    int unsigned span;
    width = 0;
    span  = 1;
    while (span < value) begin
      span  = span << 1;
      width = width + 1;
    end
    return width;
  endfunction

  // Index counters need at least one bit even for a single entry.
  function automatic int unsigned index_width(input int unsigned count);
    return (count > 1) ? clog2(count) : 1;
  endfunction

endpackage

`endif

// File: rtl/systolic_output_drain_if.sv
// Row-per-beat valid/ready result stream leaving the output drain.
interface systolic_output_drain_if #(
  parameter int num_col       = 3,
  parameter int acc_word_size = 24,
  parameter int row_width     = 2
) ();

  logic                             out_valid;
  logic                             out_ready;
  logic [0:acc_word_size*num_col-1] out_data;
  logic [row_width-1:0]             out_row;
  logic                             out_last;

  modport master (
    output out_valid,
    output out_data,
    output out_row,
    output out_last,
    input  out_ready
  );

  modport slave (
    input  out_valid,
    input  out_data,
    input  out_row,
    input  out_last,
    output out_ready
  );

endinterface

// File: rtl/systolic_output_drain_acc_bank.sv
// Accumulator bank: one acc_word_size register per PE, loaded or summed with
// the zero-extended PE snapshot, read back one array row at a time.
module systolic_output_drain_acc_bank
  import systolic_output_drain_pkg::*;
#(
  parameter int num_row       = 3,
  parameter int num_col       = 3,
  parameter int out_word_size = 16,
  parameter int acc_word_size = 24,
  parameter int row_width     = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     load,
  input  logic                                     add,
  input  logic [0:out_word_size*num_row*num_col-1] pe_vals,
  input  logic [row_width-1:0]                     rd_row,
  output logic [0:acc_word_size*num_col-1]         rd_data
);

  localparam int unsigned num_words = num_row * num_col;

  logic [acc_word_size-1:0] acc [num_words];

  always_ff @(posedge clk) begin
    if (reset) begin
      for (int unsigned i = 0; i < num_words; i++) begin
        acc[i] <= '0;
      end
    end else if (load || add) begin
      // Load restarts from zero so both paths share one adder; sums wrap.
      for (int unsigned i = 0; i < num_words; i++) begin
        acc[i] <= (load ? '0 : acc[i]) +
                  acc_word_size'(`SOD_WORD(pe_vals, out_word_size, i));
      end
    end
  end

  always_comb begin
    int unsigned row_base;
    rd_data  = '0;
    row_base = 32'(rd_row) * num_col;
    for (int unsigned c = 0; c < num_col; c++) begin
      `SOD_WORD(rd_data, acc_word_size, c) = acc[row_base + c];
    end
  end

endmodule

// File: rtl/systolic_output_drain.sv
// Collects K-tile partial sums from the systolic array, clearing the array
// after each snapshot, then streams the summed tile out one row per beat.
module systolic_output_drain
  import systolic_output_drain_pkg::*;
#(
  parameter int num_row       = 3,
  parameter int num_col       = 3,
  parameter int out_word_size = 16,
  parameter int acc_word_size = 24,
  parameter int num_k_tiles   = 2
) (
  input  logic                                     clk,
  input  logic                                     reset,
  input  logic                                     compute_done,
  input  logic [0:out_word_size*num_row*num_col-1] pe_register_vals,
  output logic                                     array_reset,
  systolic_output_drain_if.master                  drain_bus,
  output logic                                     tile_done,
  output logic                                     busy
);

  localparam int row_width = index_width(num_row);
  localparam int k_width   = index_width(num_k_tiles);

  localparam logic [row_width-1:0] last_row = row_width'(num_row - 1);
  localparam logic [k_width-1:0]   last_k   = k_width'(num_k_tiles - 1);

  drain_state_t             state, state_next;
  logic [k_width-1:0]       k_idx, k_idx_next;
  logic [row_width-1:0]     row_idx, row_idx_next;
  logic                     array_reset_next;
  logic                     out_valid, out_valid_next;
  logic                     tile_done_next;
  logic                     acc_load, acc_add;
  logic [0:acc_word_size*num_col-1] row_data;

  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= WAIT;
      k_idx       <= '0;
      row_idx     <= '0;
      array_reset <= 1'b1;
      out_valid   <= 1'b0;
      tile_done   <= 1'b0;
    end else begin
      state       <= state_next;
      k_idx       <= k_idx_next;
      row_idx     <= row_idx_next;
      array_reset <= array_reset_next;
      out_valid   <= out_valid_next;
      tile_done   <= tile_done_next;
    end
  end

  always_comb begin
    state_next       = state;
    k_idx_next       = k_idx;
    row_idx_next     = row_idx;
    array_reset_next = 1'b0;
    out_valid_next   = out_valid;
    tile_done_next   = 1'b0;
    acc_load         = 1'b0;
    acc_add          = 1'b0;

    unique case (state)
      WAIT: begin
        if (compute_done) begin
          acc_load         = (k_idx == '0);
          acc_add          = (k_idx != '0);
          array_reset_next = 1'b1;
          state_next       = CLEAR;
        end
      end
      CLEAR: begin
        if (k_idx == last_k) begin
          k_idx_next     = '0;
          row_idx_next   = '0;
          out_valid_next = 1'b1;
          state_next     = DRAIN;
        end else begin
          k_idx_next = k_idx + k_width'(1);
          state_next = SETTLE;
        end
      end
      // Holding off until done falls keeps one tile from being summed twice.
      SETTLE: begin
        if (!compute_done) begin
          state_next = WAIT;
        end
      end
      DRAIN: begin
        if (drain_bus.out_ready) begin
          if (row_idx == last_row) begin
            out_valid_next = 1'b0;
            tile_done_next = 1'b1;
            state_next     = WAIT;
          end else begin
            row_idx_next = row_idx + row_width'(1);
          end
        end
      end
      default: state_next = WAIT;
    endcase
  end

  systolic_output_drain_acc_bank #(
    .num_row       (num_row),
    .num_col       (num_col),
    .out_word_size (out_word_size),
    .acc_word_size (acc_word_size),
    .row_width     (row_width)
  ) u_acc_bank (
    .clk     (clk),
    .reset   (reset),
    .load    (acc_load),
    .add     (acc_add),
    .pe_vals (pe_register_vals),
    .rd_row  (row_idx),
    .rd_data (row_data)
  );

  assign drain_bus.out_valid = out_valid;
  assign drain_bus.out_data  = row_data;
  assign drain_bus.out_row   = row_idx;
  assign drain_bus.out_last  = out_valid && (row_idx == last_row);
  assign busy                = (state != WAIT);

endmodule

// File: tb/tb_systolic_output_drain.sv
// Self-checking bench for systolic_output_drain: random PE tiles against a
// sum-of-tiles reference, with ready patterns driven from the bench.
module tb_systolic_output_drain;

  localparam int num_row   = 3;
  localparam int num_col   = 3;
  localparam int ow        = 16;
  localparam int aw        = 24;
  localparam int nk        = 2;
  localparam int nw        = num_row * num_col;
  localparam int rw        = systolic_output_drain_pkg::index_width(num_row);

  logic              clk = 1'b0;
  logic              reset = 1'b1;
  logic              cd = 1'b0;
  logic [0:ow*nw-1]  pe_vec = '0;
  logic              array_reset, tile_done, busy;

  logic              cd2 = 1'b0;
  logic [0:ow*nw-1]  pe2 = '0;
  logic              ar2, td2, busy2;

  systolic_output_drain_if #(.num_col(num_col), .acc_word_size(aw), .row_width(rw)) bus ();
  systolic_output_drain_if #(.num_col(num_col), .acc_word_size(16), .row_width(rw)) bus16 ();

  systolic_output_drain #(
    .num_row(num_row), .num_col(num_col), .out_word_size(ow),
    .acc_word_size(aw), .num_k_tiles(nk)
  ) dut (
    .clk(clk), .reset(reset), .compute_done(cd), .pe_register_vals(pe_vec),
    .array_reset(array_reset), .drain_bus(bus), .tile_done(tile_done), .busy(busy)
  );

  systolic_output_drain #(
    .num_row(num_row), .num_col(num_col), .out_word_size(ow),
    .acc_word_size(16), .num_k_tiles(nk)
  ) dut16 (
    .clk(clk), .reset(reset), .compute_done(cd2), .pe_register_vals(pe2),
    .array_reset(ar2), .drain_bus(bus16), .tile_done(td2), .busy(busy2)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    logic [0:aw*num_col-1] data;
    logic [rw-1:0]         row;
    logic                  last;
    logic                  ready;
    int                    cyc;
  } beat_t;

  beat_t beats[$];
  int    ar_cyc[$];
  int    td_cyc[$];

  always @(negedge clk) begin
    if (!reset) begin
      if (bus.out_valid) beats.push_back('{bus.out_data, bus.out_row, bus.out_last, bus.out_ready, cyc});
      if (array_reset) ar_cyc.push_back(cyc);
      if (tile_done) td_cyc.push_back(cyc);
    end
  end

  // Downstream: 0 = never ready, 1 = always ready, 2 = random; optional stall on row 1.
  int ready_mode = 0;
  int stall_left = 0;
  always @(posedge clk) begin
    #2;
    case (ready_mode)
      0:       bus.out_ready = 1'b0;
      1:       bus.out_ready = 1'b1;
      default: bus.out_ready = 1'($urandom_range(0, 1));
    endcase
    if (stall_left > 0 && bus.out_valid && bus.out_row == 1) begin
      bus.out_ready = 1'b0;
      stall_left    = stall_left - 1;
    end
  end

  initial bus16.out_ready = 1'b1;

  // Reference: each output word is the sum of that PE over all K tiles, mod 2^aw.
  int unsigned tiles [nk][nw];

  function automatic logic [aw-1:0] expect_word(input int idx);
    longint unsigned s = 0;
    for (int k = 0; k < nk; k++) s += tiles[k][idx];
    return aw'(s % (64'd1 << aw));
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic clear_log();
    beats.delete();
    ar_cyc.delete();
    td_cyc.delete();
  endtask

  task automatic randomize_tiles();
    for (int k = 0; k < nk; k++)
      for (int i = 0; i < nw; i++) tiles[k][i] = $urandom_range(0, 16'hFFFF);
  endtask

  task automatic drive_tile(input int k, input int hold);
    logic seen;
    for (int i = 0; i < nw; i++) pe_vec[ow*i +: ow] = ow'(tiles[k][i]);
    repeat (2 + $urandom_range(0, 2)) tick();
    cd   = 1'b1;
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = array_reset;
    end
    checks++;
    if (!seen) begin
      errors++;
      $display("FAIL capture_ack tile %0d: array_reset=%b, required 1", k, array_reset);
    end
    for (int h = 0; h < hold; h++) begin
      tick();
      checks++;
      if (busy !== 1'b1 || array_reset !== 1'b0 || bus.out_valid !== 1'b0) begin
        errors++;
        $display("FAIL settle_dwell cycle %0d: busy=%b array_reset=%b out_valid=%b, required 1 0 0",
                 h, busy, array_reset, bus.out_valid);
      end
    end
    cd = 1'b0;
  endtask

  task automatic run_tiles(input int hold, input int mode, input int stall);
    clear_log();
    ready_mode = mode;
    stall_left = stall;
    drive_tile(0, hold);
    drive_tile(1, 0);
    for (int n = 0; n < 300 && td_cyc.size() == 0; n++) tick();
    checks++;
    if (td_cyc.size() == 0) begin
      errors++;
      $display("FAIL tile_done_timeout: tile_done pulses=0, required 1");
    end
    tick();
  endtask

  task automatic test_reset();
    reset = 1'b1;
    cd    = 1'b0;
    repeat (3) tick();
    checks++;
    if (array_reset !== 1'b1 || ar2 !== 1'b1) begin
      errors++;
      $display("FAIL reset_array_reset: got %b/%b, required 1/1", array_reset, ar2);
    end
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || tile_done !== 1'b0 || bus.out_last !== 1'b0) begin
      errors++;
      $display("FAIL reset_outputs: valid=%b busy=%b tile_done=%b last=%b, required 0 0 0 0",
               bus.out_valid, busy, tile_done, bus.out_last);
    end
    checks++;
    if (bus.out_row !== '0) begin
      errors++;
      $display("FAIL reset_out_row: got %0d, required 0", bus.out_row);
    end
    reset = 1'b0;
    tick();
    checks++;
    if (array_reset !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL reset_release: array_reset=%b busy=%b, required 0 0", array_reset, busy);
    end
  endtask

  task automatic test_basic_k2();
    int last_ar;
    for (int i = 0; i < nw; i++) begin
      tiles[0][i] = i + 1;
      tiles[1][i] = 10 * (i + 1);
    end
    run_tiles(0, 1, 0);
    checks++;
    if (ar_cyc.size() != 2) begin
      errors++;
      $display("FAIL basic_clear_count: got %0d array_reset cycles, required 2", ar_cyc.size());
    end else begin
      checks++;
      if (ar_cyc[1] - ar_cyc[0] < 2) begin
        errors++;
        $display("FAIL basic_clear_width: pulses at %0d,%0d, required separate 1-cycle pulses", ar_cyc[0], ar_cyc[1]);
      end
    end
    last_ar = (ar_cyc.size() > 0) ? ar_cyc[ar_cyc.size()-1] : -100;
    checks++;
    if (beats.size() != num_row) begin
      errors++;
      $display("FAIL basic_beat_count: got %0d valid cycles, required %0d", beats.size(), num_row);
    end
    foreach (beats[i]) begin
      checks++;
      if (beats[i].row !== rw'(i) || beats[i].last !== (i == num_row - 1) || beats[i].cyc != last_ar + 1 + i) begin
        errors++;
        $display("FAIL basic_beat %0d: row=%0d last=%b cyc=%0d, required row=%0d last=%b cyc=%0d",
                 i, beats[i].row, beats[i].last, beats[i].cyc, i, (i == num_row - 1), last_ar + 1 + i);
      end
      for (int c = 0; c < num_col; c++) begin
        checks++;
        if (beats[i].data[aw*c +: aw] !== expect_word(i*num_col + c)) begin
          errors++;
          $display("FAIL basic_data r%0d c%0d: got %0d, required %0d",
                   i, c, beats[i].data[aw*c +: aw], expect_word(i*num_col + c));
        end
      end
    end
    checks++;
    if (td_cyc.size() != 1 || td_cyc[0] != last_ar + 1 + num_row) begin
      errors++;
      $display("FAIL basic_tile_done: pulses=%0d first_cyc=%0d, required 1 at %0d",
               td_cyc.size(), (td_cyc.size() > 0) ? td_cyc[0] : -1, last_ar + 1 + num_row);
    end
  endtask

  task automatic test_backpressure();
    int last_ar, n_row1, n_acc;
    randomize_tiles();
    run_tiles(0, 1, 4);
    last_ar = (ar_cyc.size() > 0) ? ar_cyc[ar_cyc.size()-1] : -100;
    n_row1  = 0;
    n_acc   = 0;
    checks++;
    if (beats.size() != num_row + 4) begin
      errors++;
      $display("FAIL bp_valid_cycles: got %0d, required %0d", beats.size(), num_row + 4);
    end
    foreach (beats[i]) begin
      if (beats[i].row == 1) begin
        n_row1++;
        for (int c = 0; c < num_col; c++) begin
          checks++;
          if (beats[i].data[aw*c +: aw] !== expect_word(num_col + c)) begin
            errors++;
            $display("FAIL bp_row1_hold cyc %0d c%0d: got %0d, required %0d",
                     beats[i].cyc, c, beats[i].data[aw*c +: aw], expect_word(num_col + c));
          end
        end
      end
      if (beats[i].ready) begin
        checks++;
        if (beats[i].row !== rw'(n_acc)) begin
          errors++;
          $display("FAIL bp_row_order: accepted row %0d, required %0d", beats[i].row, n_acc);
        end
        n_acc++;
      end
    end
    checks++;
    if (n_row1 != 5 || n_acc != num_row) begin
      errors++;
      $display("FAIL bp_counts: row1 cycles=%0d accepted=%0d, required 5 and %0d", n_row1, n_acc, num_row);
    end
    checks++;
    if (td_cyc.size() != 1 || td_cyc[0] != last_ar + 1 + num_row + 4) begin
      errors++;
      $display("FAIL bp_tile_done: pulses=%0d cyc=%0d, required 1 at %0d",
               td_cyc.size(), (td_cyc.size() > 0) ? td_cyc[0] : -1, last_ar + 1 + num_row + 4);
    end
  endtask

  task automatic test_no_double_capture();
    randomize_tiles();
    run_tiles(5, 1, 0);
    checks++;
    if (ar_cyc.size() != 2) begin
      errors++;
      $display("FAIL ndc_clear_count: got %0d, required 2", ar_cyc.size());
    end
    checks++;
    if (beats.size() != num_row) begin
      errors++;
      $display("FAIL ndc_beat_count: got %0d, required %0d", beats.size(), num_row);
    end
    foreach (beats[i]) begin
      for (int c = 0; c < num_col; c++) begin
        checks++;
        if (beats[i].data[aw*c +: aw] !== expect_word(int'(beats[i].row)*num_col + c)) begin
          errors++;
          $display("FAIL ndc_data r%0d c%0d: got %0d, required %0d", beats[i].row, c,
                   beats[i].data[aw*c +: aw], expect_word(int'(beats[i].row)*num_col + c));
        end
      end
    end
  endtask

  task automatic test_random_stream();
    for (int it = 0; it < 4; it++) begin
      int n_acc, last_acc_cyc;
      randomize_tiles();
      run_tiles(0, 2, 0);
      n_acc        = 0;
      last_acc_cyc = -100;
      foreach (beats[i]) begin
        if (beats[i].ready) begin
          checks++;
          if (beats[i].row !== rw'(n_acc) || beats[i].last !== (n_acc == num_row - 1)) begin
            errors++;
            $display("FAIL rnd_row it%0d: row=%0d last=%b, required %0d %b",
                     it, beats[i].row, beats[i].last, n_acc, (n_acc == num_row - 1));
          end
          for (int c = 0; c < num_col; c++) begin
            checks++;
            if (beats[i].data[aw*c +: aw] !== expect_word(n_acc*num_col + c)) begin
              errors++;
              $display("FAIL rnd_data it%0d r%0d c%0d: got %0d, required %0d", it, n_acc, c,
                       beats[i].data[aw*c +: aw], expect_word(n_acc*num_col + c));
            end
          end
          n_acc++;
          last_acc_cyc = beats[i].cyc;
        end else if (i + 1 < beats.size()) begin
          checks++;
          if (beats[i+1].data !== beats[i].data || beats[i+1].row !== beats[i].row) begin
            errors++;
            $display("FAIL rnd_hold it%0d cyc %0d: row %0d changed to %0d while not accepted",
                     it, beats[i].cyc, beats[i].row, beats[i+1].row);
          end
        end
      end
      checks++;
      if (n_acc != num_row || td_cyc.size() != 1 || td_cyc[0] != last_acc_cyc + 1) begin
        errors++;
        $display("FAIL rnd_done it%0d: accepted=%0d pulses=%0d, required %0d and 1 pulse at %0d",
                 it, n_acc, td_cyc.size(), num_row, last_acc_cyc + 1);
      end
    end
  endtask

  task automatic test_reset_mid_drain();
    int n_acc;
    logic seen;
    randomize_tiles();
    clear_log();
    ready_mode = 0;
    drive_tile(0, 0);
    drive_tile(1, 0);
    seen = 1'b0;
    for (int n = 0; n < 20 && !seen; n++) begin
      tick();
      seen = bus.out_valid;
    end
    ready_mode = 1;
    tick();
    ready_mode = 0;
    reset      = 1'b1;
    tick();
    checks++;
    if (bus.out_valid !== 1'b0 || busy !== 1'b0 || tile_done !== 1'b0 || array_reset !== 1'b1) begin
      errors++;
      $display("FAIL mid_reset_state: valid=%b busy=%b tile_done=%b array_reset=%b, required 0 0 0 1",
               bus.out_valid, busy, tile_done, array_reset);
    end
    n_acc = 0;
    foreach (beats[i]) if (beats[i].ready) n_acc++;
    checks++;
    if (!seen || n_acc != 1) begin
      errors++;
      $display("FAIL mid_reset_progress: valid_seen=%b accepted=%0d, required 1 and 1", seen, n_acc);
    end
    reset = 1'b0;
    repeat (5) tick();
    checks++;
    if (td_cyc.size() != 0) begin
      errors++;
      $display("FAIL mid_reset_no_done: got %0d tile_done pulses, required 0", td_cyc.size());
    end
    randomize_tiles();
    run_tiles(0, 1, 0);
    checks++;
    if (beats.size() != num_row) begin
      errors++;
      $display("FAIL fresh_beat_count: got %0d, required %0d", beats.size(), num_row);
    end
    foreach (beats[i]) begin
      for (int c = 0; c < num_col; c++) begin
        checks++;
        if (beats[i].data[aw*c +: aw] !== expect_word(int'(beats[i].row)*num_col + c)) begin
          errors++;
          $display("FAIL fresh_data r%0d c%0d: got %0d, required %0d", beats[i].row, c,
                   beats[i].data[aw*c +: aw], expect_word(int'(beats[i].row)*num_col + c));
        end
      end
    end
  endtask

  task automatic test_wrap();
    int   n_beats;
    int   n_done;
    logic seen;
    pe2 = '1;
    for (int k = 0; k < nk; k++) begin
      repeat (3) tick();
      cd2  = 1'b1;
      seen = 1'b0;
      for (int n = 0; n < 20 && !seen; n++) begin
        tick();
        seen = ar2;
      end
      cd2 = 1'b0;
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL wrap_capture tile %0d: array_reset=%b, required 1", k, ar2);
      end
    end
    n_beats = 0;
    n_done  = 0;
    for (int n = 0; n < 10; n++) begin
      tick();
      if (td2) n_done++;
      if (bus16.out_valid) begin
        checks++;
        if (bus16.out_row !== rw'(n_beats)) begin
          errors++;
          $display("FAIL wrap_row: got %0d, required %0d", bus16.out_row, n_beats);
        end
        for (int c = 0; c < num_col; c++) begin
          checks++;
          if (bus16.out_data[16*c +: 16] !== 16'hFFFE) begin
            errors++;
            $display("FAIL wrap_data r%0d c%0d: got %h, required fffe", n_beats, c, bus16.out_data[16*c +: 16]);
          end
        end
        n_beats++;
      end
    end
    checks++;
    if (n_beats != num_row || n_done != 1) begin
      errors++;
      $display("FAIL wrap_counts: beats=%0d tile_done=%0d, required %0d and 1", n_beats, n_done, num_row);
    end
  endtask

  initial begin
    test_reset();
    test_basic_k2();
    test_backpressure();
    test_no_double_capture();
    test_random_stream();
    test_reset_mid_drain();
    test_wrap();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish within time limit");
    $fatal(1, "watchdog expired");
  end

endmodule
